// File: rtl/uart_read_if.sv
// uart_read_if
//   Consumer-side bundle of the UART receiver.
//   read_ce   consumer acknowledge (clears rready and overrun)
//   dout      last good received byte
//   rready    dout holds an unread byte (sticky)
//   overrun   a good byte overwrote an unread one (sticky)
//   frame_err one-cycle pulse when a stop bit is sampled low
//   master: receiver side, slave: consumer side.
interface uart_read_if;
    logic       read_ce;
    logic [7:0] dout;
    logic       rready;
    logic       overrun;
    logic       frame_err;

    modport master (
        input  read_ce,
        output dout,
        output rready,
        output overrun,
        output frame_err
    );

    modport slave (
        output read_ce,
        input  dout,
        input  rready,
        input  overrun,
        input  frame_err
    );
endinterface

// File: rtl/uart_read.sv
// uart_read
//   8N1 UART receiver, LSB first, running on the core clock. rxd is
//   double-synchronised, each frame is found on the start-bit falling edge,
//   every bit is sampled at mid-bit and the byte lands in a single-entry
//   output register with a ready/acknowledge handshake.
//   Ports:
//     clk  core clock
//     rst  asynchronous active-high reset
//     rxd  serial line (asynchronous, idle high)
//     rd   consumer bundle: read_ce in; dout, rready, overrun, frame_err out
module uart_read #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    uart_read_if.master rd
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic [7:0]    dout_q;
    logic          rready_q;
    logic          overrun_q;
    logic          frame_err_q;

    assign rd.dout      = dout_q;
    assign rd.rready    = rready_q;
    assign rd.overrun   = overrun_q;
    assign rd.frame_err = frame_err_q;

    // Two-stage synchroniser; reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bitn        <= '0;
            shreg       <= '0;
            dout_q      <= '0;
            rready_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // Acknowledge first; a good stop in the same cycle overrides
            // rready below, so the new byte is never lost.
            if (rd.read_ce) begin
                rready_q  <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            bitn  <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: ignore.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        // Leaving at mid-stop gives half a bit of slack to
                        // catch a back-to-back start edge.
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            dout_q   <= shreg;
                            rready_q <= 1'b1;
                            if (rready_q && !rd.read_ce) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_read.sv
// tb_uart_read
//   Self-checking bench for uart_read at CLK_FREQ=160, BAUD=10 (16 clocks
//   per bit). Expected bytes are queued as frames are driven and popped by a
//   monitor whenever the receiver publishes a byte; a vector table covers
//   single frames, hand-written sequences cover glitch, back-to-back,
//   mid-frame reset and same-cycle acknowledge.
module tb_uart_read;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int CPB      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_read_if bus ();

    uart_read #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .rd  (bus)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ferr_cnt = 0;
    int rise_cyc = -1;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_rready;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a byte is published when rready rises or dout
    // changes while rready is held.
    initial begin : monitor
        logic       prev_rr;
        logic [7:0] prev_dout;
        logic [7:0] e;
        prev_rr   = 1'b0;
        prev_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rready && (!prev_rr || bus.dout != prev_dout)) begin
                    rise_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rx_byte: got unexpected %0h expected none", bus.dout);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(bus.dout), 32'(e));
                    end
                end
                if (bus.frame_err) ferr_cnt++;
            end
            prev_rr   = bus.rready;
            prev_dout = bus.dout;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            idle(CPB);
        end
        rxd = 1'b1;
    endtask

    task automatic ack();
        bus.read_ce = 1'b1;
        idle(1);
        bus.read_ce = 1'b0;
    endtask

    initial begin : main
        int start;
        int lat;

        vecs[0] = '{8'hA3, 1'b0, 8'h55, 1'b0, 1};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
        vecs[3] = '{8'h80, 1'b0, 8'hFF, 1'b0, 1};
        vecs[4] = '{8'h69, 1'b1, 8'h69, 1'b1, 0};

        bus.read_ce = 1'b0;
        rxd = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        check("reset_dout",      32'(bus.dout),      32'h00);
        check("reset_rready",    32'(bus.rready),    32'h0);
        check("reset_overrun",   32'(bus.overrun),   32'h0);
        check("reset_frame_err", 32'(bus.frame_err), 32'h0);

        // Single good frame with latency measurement.
        ferr_cnt = 0;
        exp_q.push_back(8'h55);
        start = cyc;
        send_frame(8'h55, 1'b1);
        idle(4);
        lat = rise_cyc - start;
        check("latency_in_window", 32'(lat >= 153 && lat <= 157), 32'h1);
        check("f55_dout",   32'(bus.dout),   32'h55);
        check("f55_rready", 32'(bus.rready), 32'h1);
        check("f55_ferr",   32'(ferr_cnt),   32'h0);
        ack();
        check("f55_ack_rready", 32'(bus.rready), 32'h0);

        for (int i = 0; i < 5; i++) begin
            ferr_cnt = 0;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            idle(4);
            check("vec_dout",    32'(bus.dout),    32'(vecs[i].exp_dout));
            check("vec_rready",  32'(bus.rready),  32'(vecs[i].exp_rready));
            check("vec_overrun", 32'(bus.overrun), 32'h0);
            check("vec_ferr",    32'(ferr_cnt),    32'(vecs[i].exp_ferr));
            ack();
            check("vec_ack_rready", 32'(bus.rready), 32'h0);
        end

        // Short start glitch.
        ferr_cnt = 0;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        check("glitch_rready", 32'(bus.rready), 32'h0);
        check("glitch_ferr",   32'(ferr_cnt),   32'h0);
        check("glitch_dout",   32'(bus.dout),   32'h69);

        // Back-to-back frames without acknowledge.
        ferr_cnt = 0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(4);
        check("b2b_dout",    32'(bus.dout),    32'h34);
        check("b2b_rready",  32'(bus.rready),  32'h1);
        check("b2b_overrun", 32'(bus.overrun), 32'h1);
        check("b2b_ferr",    32'(ferr_cnt),    32'h0);
        ack();
        check("b2b_ack_rready",  32'(bus.rready),  32'h0);
        check("b2b_ack_overrun", 32'(bus.overrun), 32'h0);

        // Reset after three data bits of 0xFF.
        rxd = 1'b0;
        idle(CPB);
        rxd = 1'b1;
        idle(3 * CPB);
        rst = 1'b1;
        idle(3);
        check("midrst_dout",      32'(bus.dout),      32'h00);
        check("midrst_rready",    32'(bus.rready),    32'h0);
        check("midrst_overrun",   32'(bus.overrun),   32'h0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
        rst = 1'b0;
        idle(4);
        ferr_cnt = 0;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(4);
        check("after_rst_dout",   32'(bus.dout),   32'hC3);
        check("after_rst_rready", 32'(bus.rready), 32'h1);
        check("after_rst_ferr",   32'(ferr_cnt),   32'h0);

        // Acknowledge in the same cycle a new byte completes (rready=1).
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                idle(154);
                bus.read_ce = 1'b1;
                idle(1);
                bus.read_ce = 1'b0;
            end
        join
        idle(4);
        check("same_cyc_dout",    32'(bus.dout),    32'h7E);
        check("same_cyc_rready",  32'(bus.rready),  32'h1);
        check("same_cyc_overrun", 32'(bus.overrun), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
